// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: RISC-V field
// positions, opcodes, operand-select encodings and FSM state constants.
package hazard_pkg;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_MSB = 6;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS2_MSB = 24;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [1:0] SEL_M     = 2'b10;
    localparam logic [1:0] SEL_W     = 2'b11;
    localparam logic [1:0] SEL_STORE = 2'b01;
    localparam logic [1:0] BHM_NONE  = 2'b00;
    localparam logic [1:0] BHM_M     = 2'b01;
    localparam logic [1:0] BHM_W     = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t ST_RUN    = 1'b0;
    localparam state_t ST_LSTALL = 1'b1;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle for hazard_fwd_unit. The counter signals exist
// only when HAZARD_PERF_EN is defined.
interface hazard_fwd_unit_if #(
    parameter int AWIDTH = 32
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
);
    logic [AWIDTH-1:0] instr_d;
    logic [AWIDTH-1:0] instr_x;
    logic [AWIDTH-1:0] instr_m;
    logic [AWIDTH-1:0] instr_w;
    logic              regwen_x;
    logic              regwen_m;
    logic              regwen_w;
    logic              branch_taken_x;
    logic [1:0]        asel_e;
    logic [1:0]        bsel_e;
    logic [1:0]        asel_fcu;
    logic [1:0]        bsel_fcu;
    logic [1:0]        bhm;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_x;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    modport master (
        output instr_d, instr_x, instr_m, instr_w,
        output regwen_x, regwen_m, regwen_w, branch_taken_x, asel_e, bsel_e,
        input  asel_fcu, bsel_fcu, bhm, stall_f, stall_d, flush_d, flush_x
`ifdef HAZARD_PERF_EN
        ,
        input  stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  instr_d, instr_x, instr_m, instr_w,
        input  regwen_x, regwen_m, regwen_w, branch_taken_x, asel_e, bsel_e,
        output asel_fcu, bsel_fcu, bhm, stall_f, stall_d, flush_d, flush_x
`ifdef HAZARD_PERF_EN
        ,
        output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// Operand forwarding select: picks MEM or WB as the source for the EX
// operands, MEM having priority. Store data is routed through bhm.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rd_m_i,
    input  logic [4:0] rd_w_i,
    input  logic [4:0] rs1_x_i,
    input  logic [4:0] rs2_x_i,
    input  logic [6:0] opc_x_i,
    input  logic       regwen_m_i,
    input  logic       regwen_w_i,
    input  logic [1:0] asel_e_i,
    input  logic [1:0] bsel_e_i,
    output logic [1:0] asel_o,
    output logic [1:0] bsel_o,
    output logic [1:0] bhm_o
);

    logic m_rs1, w_rs1, m_rs2, w_rs2, x_load, x_store;

    assign x_load  = (opc_x_i == OPC_LOAD);
    assign x_store = (opc_x_i == OPC_STORE);
    assign m_rs1   = regwen_m_i && (rd_m_i != '0) && (rd_m_i == rs1_x_i);
    assign w_rs1   = regwen_w_i && (rd_w_i != '0) && (rd_w_i == rs1_x_i);
    assign m_rs2   = !x_load && regwen_m_i && (rd_m_i != '0) && (rd_m_i == rs2_x_i);
    assign w_rs2   = !x_load && regwen_w_i && (rd_w_i != '0) && (rd_w_i == rs2_x_i);

    // rs1 source: MEM beats WB, otherwise the decoder's choice
    always_comb begin
        asel_o = asel_e_i;
        if (m_rs1) begin
            asel_o = SEL_M;
        end else if (w_rs1) begin
            asel_o = SEL_W;
        end
    end

    // rs2 source; stores keep the B operand for the address and forward via bhm
    always_comb begin
        bsel_o = bsel_e_i;
        bhm_o  = BHM_NONE;
        if (m_rs2) begin
            bsel_o = x_store ? SEL_STORE : SEL_M;
            bhm_o  = x_store ? BHM_M : BHM_NONE;
        end else if (w_rs2) begin
            bsel_o = x_store ? SEL_STORE : SEL_W;
            bhm_o  = x_store ? BHM_W : BHM_NONE;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding unit. Load-use hazards stall F/D and
// bubble X for LOAD_LAT cycles; a taken branch in EX overrides everything.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int AWIDTH   = 32,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_fwd_unit_if.slave bus
);

    localparam logic [3:0] CNT_INIT = (LOAD_LAT > 1) ? 4'(LOAD_LAT - 2) : 4'd0;

    if (AWIDTH < 25 || LOAD_LAT < 1 || LOAD_LAT > 15 || CNT_W < 1) begin : g_param_check
        $error("hazard_fwd_unit: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] rd_x, rs1_d, rs2_d;
    logic [6:0] opc_x, opc_d;
    logic       d_uses_rs2, hazard;
    logic       stall_f, stall_d, flush_d, flush_x;

    assign rd_x  = bus.instr_x[RD_MSB:RD_LSB];
    assign opc_x = bus.instr_x[OPC_MSB:OPC_LSB];
    assign rs1_d = bus.instr_d[RS1_MSB:RS1_LSB];
    assign rs2_d = bus.instr_d[RS2_MSB:RS2_LSB];
    assign opc_d = bus.instr_d[OPC_MSB:OPC_LSB];

    assign d_uses_rs2 = (opc_d == OPC_OP) || (opc_d == OPC_STORE) || (opc_d == OPC_BRANCH);
    assign hazard     = (opc_x == OPC_LOAD) && bus.regwen_x && (rd_x != '0) &&
                        ((rd_x == rs1_d) || ((rd_x == rs2_d) && d_uses_rs2));

    fwd_sel u_fwd_sel (
        .rd_m_i     (bus.instr_m[RD_MSB:RD_LSB]),
        .rd_w_i     (bus.instr_w[RD_MSB:RD_LSB]),
        .rs1_x_i    (bus.instr_x[RS1_MSB:RS1_LSB]),
        .rs2_x_i    (bus.instr_x[RS2_MSB:RS2_LSB]),
        .opc_x_i    (opc_x),
        .regwen_m_i (bus.regwen_m),
        .regwen_w_i (bus.regwen_w),
        .asel_e_i   (bus.asel_e),
        .bsel_e_i   (bus.bsel_e),
        .asel_o     (bus.asel_fcu),
        .bsel_o     (bus.bsel_fcu),
        .bhm_o      (bus.bhm)
    );

    // Next state and pipeline control; outputs held low while in reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_x = 1'b0;
        if (bus.branch_taken_x) begin
            flush_d = 1'b1;
            flush_x = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (state_q == ST_LSTALL) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_x = 1'b1;
            if (cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_x = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = ST_LSTALL;
                cnt_d   = CNT_INIT;
            end
        end
        if (!rst_n) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b0;
            flush_x = 1'b0;
        end
    end

    // FSM state and stall down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall_f = stall_f;
    assign bus.stall_d = stall_d;
    assign bus.flush_d = flush_d;
    assign bus.flush_x = flush_x;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counts of decode-stall and decode-flush cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_d && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_d && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: two instances (LOAD_LAT=3 and LOAD_LAT=1)
// share one stimulus stream; a reference model is checked every cycle and
// directed vectors pin hand-computed values.
module tb_hazard_fwd_unit;
    import hazard_pkg::*;

    typedef struct packed {
        logic [1:0] asel, bsel, bhm;
        logic       sf, sd, fd, fx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] instr_d, instr_x, instr_m, instr_w;
    logic        regwen_x, regwen_m, regwen_w, branch_taken_x;
    logic [1:0]  asel_e, bsel_e;

    int total = 0;
    int bad   = 0;

    hazard_fwd_unit_if #(.AWIDTH(32)) bus3 ();
    hazard_fwd_unit_if #(.AWIDTH(32)) bus1 ();

    assign bus3.instr_d = instr_d;   assign bus1.instr_d = instr_d;
    assign bus3.instr_x = instr_x;   assign bus1.instr_x = instr_x;
    assign bus3.instr_m = instr_m;   assign bus1.instr_m = instr_m;
    assign bus3.instr_w = instr_w;   assign bus1.instr_w = instr_w;
    assign bus3.regwen_x = regwen_x; assign bus1.regwen_x = regwen_x;
    assign bus3.regwen_m = regwen_m; assign bus1.regwen_m = regwen_m;
    assign bus3.regwen_w = regwen_w; assign bus1.regwen_w = regwen_w;
    assign bus3.branch_taken_x = branch_taken_x;
    assign bus1.branch_taken_x = branch_taken_x;
    assign bus3.asel_e = asel_e;     assign bus1.asel_e = asel_e;
    assign bus3.bsel_e = bsel_e;     assign bus1.bsel_e = bsel_e;

    hazard_fwd_unit #(.AWIDTH(32), .LOAD_LAT(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));
    hazard_fwd_unit #(.AWIDTH(32), .LOAD_LAT(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] r_op(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), OPC_OP};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return {7'd0, 5'(imm), 5'(rs1), 3'b010, 5'(rd), OPC_LOAD};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, OPC_STORE};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {7'd0, 5'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
    endfunction
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- reference model ----------------
    // Which stage (0 none, 1 MEM, 2 WB) supplies register r to EX
    function automatic int src_stage(input int r);
        int m_rd, w_rd;
        m_rd = int'(instr_m[11:7]);
        w_rd = int'(instr_w[11:7]);
        if (r != 0 && regwen_m && m_rd == r) return 1;
        if (r != 0 && regwen_w && w_rd == r) return 2;
        return 0;
    endfunction

    function automatic bit load_use();
        int xrd, drs1, drs2, dop;
        xrd  = int'(instr_x[11:7]);
        drs1 = int'(instr_d[19:15]);
        drs2 = int'(instr_d[24:20]);
        dop  = int'(instr_d[6:0]);
        if (instr_x[6:0] != 7'h03 || !regwen_x || xrd == 0) return 0;
        if (xrd == drs1) return 1;
        return (xrd == drs2) && (dop == 'h33 || dop == 'h23 || dop == 'h63);
    endfunction

    // stall_left = bubble cycles still owed after the current one
    function automatic exp_t model(input int stall_left);
        exp_t e;
        int   s1, s2;
        bit   is_store;
        e = '0;
        s1 = src_stage(int'(instr_x[19:15]));
        s2 = (instr_x[6:0] == 7'h03) ? 0 : src_stage(int'(instr_x[24:20]));
        is_store = (instr_x[6:0] == 7'h23);
        e.asel = (s1 == 1) ? 2'b10 : (s1 == 2) ? 2'b11 : asel_e;
        e.bsel = bsel_e;
        e.bhm  = 2'b00;
        if (s2 != 0) begin
            e.bsel = is_store ? 2'b01 : ((s2 == 1) ? 2'b10 : 2'b11);
            e.bhm  = is_store ? ((s2 == 1) ? 2'b01 : 2'b10) : 2'b00;
        end
        if (branch_taken_x) begin
            e.fd = 1'b1;
            e.fx = 1'b1;
        end else if (stall_left > 0 || load_use()) begin
            e.sf = 1'b1;
            e.sd = 1'b1;
            e.fx = 1'b1;
        end
        return e;
    endfunction

    function automatic int next_left(input int lat, input int stall_left);
        if (branch_taken_x) return 0;
        if (stall_left > 0) return stall_left - 1;
        if (load_use()) return lat - 1;
        return 0;
    endfunction

    int          left3 = 0, left1 = 0;
    logic [31:0] sc3 = '0, fc3 = '0, sc1 = '0, fc1 = '0;

    always @(posedge clk or negedge rst_n) begin
        exp_t e3, e1;
        if (!rst_n) begin
            left3 = 0; left1 = 0;
            sc3 = '0; fc3 = '0; sc1 = '0; fc1 = '0;
        end else begin
            e3 = model(left3);
            e1 = model(left1);
            if (e3.sd && sc3 != 32'hFFFF_FFFF) sc3 = sc3 + 1;
            if (e3.fd && fc3 != 32'hFFFF_FFFF) fc3 = fc3 + 1;
            if (e1.sd && sc1 != 32'hFFFF_FFFF) sc1 = sc1 + 1;
            if (e1.fd && fc1 != 32'hFFFF_FFFF) fc1 = fc1 + 1;
            left3 = next_left(3, left3);
            left1 = next_left(1, left1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] h, input logic sf,
                           input logic sd, input logic fd, input logic fx);
        chk({tag, ".asel_fcu"}, 32'(a), 32'(e.asel));
        chk({tag, ".bsel_fcu"}, 32'(b), 32'(e.bsel));
        chk({tag, ".bhm"},      32'(h), 32'(e.bhm));
        chk({tag, ".stall_f"},  32'(sf), 32'(e.sf));
        chk({tag, ".stall_d"},  32'(sd), 32'(e.sd));
        chk({tag, ".flush_d"},  32'(fd), 32'(e.fd));
        chk({tag, ".flush_x"},  32'(fx), 32'(e.fx));
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            cmp_all("m3", model(left3), bus3.asel_fcu, bus3.bsel_fcu, bus3.bhm,
                    bus3.stall_f, bus3.stall_d, bus3.flush_d, bus3.flush_x);
            cmp_all("m1", model(left1), bus1.asel_fcu, bus1.bsel_fcu, bus1.bhm,
                    bus1.stall_f, bus1.stall_d, bus1.flush_d, bus1.flush_x);
`ifdef HAZARD_PERF_EN
            chk("m3.stall_cnt", bus3.stall_cnt, sc3);
            chk("m3.flush_cnt", bus3.flush_cnt, fc3);
            chk("m1.stall_cnt", bus1.stall_cnt, sc1);
            chk("m1.flush_cnt", bus1.flush_cnt, fc1);
`endif
        end
    end

    // One cycle of stimulus: drive just after the rising edge, return at the falling edge
    task automatic set(input logic [31:0] d, input logic [31:0] x, input logic [31:0] m,
                       input logic [31:0] w, input logic rx, input logic rm, input logic rw,
                       input logic br, input logic [1:0] ae, input logic [1:0] be);
        @(posedge clk);
        #1;
        instr_d = d; instr_x = x; instr_m = m; instr_w = w;
        regwen_x = rx; regwen_m = rm; regwen_w = rw; branch_taken_x = br;
        asel_e = ae; bsel_e = be;
        @(negedge clk);
    endtask

    task automatic nop_cycle();
        set(NOP, NOP, NOP, NOP, 0, 0, 0, 0, 2'b00, 2'b00);
    endtask

    task automatic hazard_cycle(input logic br);
        set(r_op(1, 5, 2), lw(5, 2, 0), NOP, NOP, 1, 0, 0, br, 2'b00, 2'b00);
    endtask

    initial begin
        // reset applied with a load-use hazard on the inputs
        instr_d = r_op(1, 5, 2); instr_x = lw(5, 2, 0); instr_m = NOP; instr_w = NOP;
        regwen_x = 1; regwen_m = 0; regwen_w = 0; branch_taken_x = 0;
        asel_e = 2'b00; bsel_e = 2'b00;
        #2;
        chk("rst.stall_f", 32'(bus3.stall_f), 0);
        chk("rst.stall_d", 32'(bus3.stall_d), 0);
        chk("rst.flush_x", 32'(bus3.flush_x), 0);
        chk("rst.stall_d1", 32'(bus1.stall_d), 0);
`ifdef HAZARD_PERF_EN
        chk("rst.stall_cnt", bus3.stall_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // forwarding
        set(NOP, r_op(6, 5, 7), r_op(5, 1, 2), NOP, 0, 1, 0, 0, 2'b00, 2'b00);
        chk("fwd_a_mem", 32'(bus3.asel_fcu), 32'h2);
        chk("fwd_b_none", 32'(bus3.bsel_fcu), 32'h0);
        set(NOP, r_op(6, 5, 7), NOP, r_op(5, 1, 2), 0, 0, 1, 0, 2'b00, 2'b00);
        chk("fwd_a_wb", 32'(bus3.asel_fcu), 32'h3);
        set(NOP, r_op(6, 5, 5), r_op(5, 1, 2), r_op(5, 3, 4), 0, 1, 1, 0, 2'b00, 2'b00);
        chk("fwd_a_mem_over_wb", 32'(bus3.asel_fcu), 32'h2);
        chk("fwd_b_mem", 32'(bus3.bsel_fcu), 32'h2);
        chk("fwd_b_mem_bhm", 32'(bus3.bhm), 32'h0);
        set(NOP, sw(5, 1), NOP, r_op(5, 1, 2), 0, 1, 1, 0, 2'b00, 2'b00);
        chk("st_wb_bsel", 32'(bus3.bsel_fcu), 32'h1);
        chk("st_wb_bhm", 32'(bus3.bhm), 32'h2);
        set(NOP, sw(5, 1), r_op(5, 1, 2), NOP, 0, 1, 0, 0, 2'b00, 2'b00);
        chk("st_mem_bhm", 32'(bus3.bhm), 32'h1);
        set(NOP, lw(6, 1, 5), r_op(5, 1, 2), NOP, 0, 1, 0, 0, 2'b00, 2'b01);
        chk("ld_no_rs2_fwd", 32'(bus3.bsel_fcu), 32'h1);
        chk("ld_no_rs2_bhm", 32'(bus3.bhm), 32'h0);
        set(NOP, r_op(6, 0, 0), r_op(0, 1, 2), r_op(0, 3, 4), 0, 1, 1, 0, 2'b01, 2'b11);
        chk("x0_asel", 32'(bus3.asel_fcu), 32'h1);
        chk("x0_bsel", 32'(bus3.bsel_fcu), 32'h3);

        // load-use stall, LOAD_LAT=3: three stall cycles then released
        for (int i = 0; i < 3; i++) begin
            hazard_cycle(0);
            chk("lu_stall_d", 32'(bus3.stall_d), 1);
            chk("lu_flush_x", 32'(bus3.flush_x), 1);
            chk("lu_flush_d", 32'(bus3.flush_d), 0);
        end
        set(NOP, r_op(1, 5, 2), NOP, NOP, 1, 0, 0, 0, 2'b00, 2'b00);
        chk("lu_done_stall_d", 32'(bus3.stall_d), 0);
        chk("lu_done_flush_x", 32'(bus3.flush_x), 0);

        // rs2 hazard only for OP/STORE/BRANCH consumers, never for x0
        set(sw(5, 3), lw(5, 2, 0), NOP, NOP, 1, 0, 0, 0, 2'b00, 2'b00);
        chk("st_hazard", 32'(bus3.stall_d), 1);
        repeat (3) nop_cycle();
        set(addi(1, 3, 5), lw(5, 2, 0), NOP, NOP, 1, 0, 0, 0, 2'b00, 2'b00);
        chk("opimm_no_hazard", 32'(bus3.stall_d), 0);
        set(r_op(1, 0, 2), lw(0, 2, 0), NOP, NOP, 1, 0, 0, 0, 2'b00, 2'b00);
        chk("x0_no_hazard", 32'(bus3.stall_d), 0);

        // branch during LSTALL wins and returns to RUN
        hazard_cycle(0);
        hazard_cycle(1);
        chk("br_ls_flush_d", 32'(bus3.flush_d), 1);
        chk("br_ls_flush_x", 32'(bus3.flush_x), 1);
        chk("br_ls_stall_d", 32'(bus3.stall_d), 0);
        nop_cycle();
        chk("br_ls_after", 32'(bus3.stall_d), 0);
        // branch beats a hazard seen in RUN
        hazard_cycle(1);
        chk("br_run_stall_f", 32'(bus3.stall_f), 0);
        chk("br_run_flush_d", 32'(bus3.flush_d), 1);
        nop_cycle();
        chk("br_run_after", 32'(bus3.stall_d), 0);

        // reset pulse mid-stall aborts it
        hazard_cycle(0);
        nop_cycle();
        chk("rst_mid_pre", 32'(bus3.stall_d), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_stall_d", 32'(bus3.stall_d), 0);
        chk("rst_mid_flush_x", 32'(bus3.flush_x), 0);
        #1 rst_n = 1'b1;
        nop_cycle();
        chk("rst_mid_after", 32'(bus3.stall_d), 0);

`ifdef HAZARD_PERF_EN
        // counters: two hazards and one branch from a fresh reset
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        hazard_cycle(0); nop_cycle(); nop_cycle();
        hazard_cycle(0); nop_cycle(); nop_cycle();
        set(NOP, NOP, NOP, NOP, 0, 0, 0, 1, 2'b00, 2'b00);
        nop_cycle();
        chk("perf3_stall_cnt", bus3.stall_cnt, 6);
        chk("perf3_flush_cnt", bus3.flush_cnt, 1);
        chk("perf1_stall_cnt", bus1.stall_cnt, 2);
        chk("perf1_flush_cnt", bus1.flush_cnt, 1);
`endif

        nop_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
